rf_dump_reader: RTL and testbench

- Debug read-out engine on the register file's side-channel read port (reg_sel/reg_data).
- On a start command, walks a register index range and streams each register's index and value out over a valid/ready interface toward the debug/trace host.
- Runs alongside the pipeline on posedge clk. It never writes the register file.

---
 rtl/rf_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_rf_dump_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: debug read-out engine on the register file side-read port.
// After a start command it walks the index range first_reg..last_reg
// (inclusive). For each index it reads reg_data through reg_sel and offers
// the {index, value} pair as one beat on a valid/ready stream toward the
// debug host. It never writes the register file.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; reg_sel parked at 0
// READ  | reg_sel=idx; reg_data captured into the beat at the next edge
// HOLD  | beat offered (out_valid=1) and held stable until accepted
// DONE  | one cycle: done pulse (with err if the range was invalid)
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle dump request, sampled only in IDLE
//   first_reg, last_reg   inclusive index range, latched on accepted start
//   abort                 cancels a dump in progress (no done/err pulse)
//   reg_sel / reg_data    register file side-read port (combinational data)
//   out_valid/out_ready   beat handshake; out_idx/out_data carry the beat
//   busy                  state != IDLE
//   done, err             registered one-cycle pulses at the end of a dump
//   beat_cnt              beats accepted in the current or last dump
module rf_dump_reader #(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_reg,
    input  logic [IDX_W-1:0]  last_reg,
    input  logic              abort,
    output logic [IDX_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W:0]    beat_cnt
);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE = (IDX_W + 1)'(1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                out_valid_q, out_valid_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [IDX_W:0]      beat_cnt_q, beat_cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        beat_cnt_d  = beat_cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        reg_sel     = '0;

        unique case (state_q)
            IDLE: begin
                // abort is not looked at here, so start wins over abort.
                if (start) begin
                    beat_cnt_d = '0;
                    if (first_reg <= last_reg) begin
                        last_d  = last_reg;
                        idx_d   = first_reg;
                        state_d = READ;
                    end else begin
                        // The pulses are registered, so they are set on the
                        // edge entering DONE and are visible during DONE.
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                reg_sel = idx_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    out_data_d  = reg_data;
                    out_idx_d   = idx_q;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    // abort beats a simultaneous handshake; the beat is dropped
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_valid_q && out_ready) begin
                    beat_cnt_d  = beat_cnt_q + CNT_ONE;
                    out_valid_d = 1'b0;
                    // Terminating on equality keeps last_reg = all-ones from
                    // wrapping idx back to 0.
                    if (idx_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            beat_cnt_q  <= beat_cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic [IDX_W-1:0]  first_reg;
    logic [IDX_W-1:0]  last_reg;
    logic              abort;
    logic [IDX_W-1:0]  reg_sel;
    logic [DATA_W-1:0] reg_data;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W:0]    beat_cnt;

    logic [DATA_W-1:0] regs [32];

    int checks = 0;
    int errors = 0;

    rf_dump_reader #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .abort     (abort),
        .reg_sel   (reg_sel),
        .reg_data  (reg_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .beat_cnt  (beat_cnt)
    );

    // register file side-read model, r0 hardwired to zero
    assign reg_data = (reg_sel == '0) ? '0 : regs[reg_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        first_reg = '0;
        last_reg  = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        for (int n = 0; n < 32; n++) regs[n] = 32'h1000 + n;

        // reset state
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_err", 64'({done, err}), 64'd0);
        chk("rst_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_sel", 64'(reg_sel), 64'd0);
        rst = 1'b0;
        tick();

        // full dump 0..31, consumer always ready
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd31; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("full_read_busy", 64'(busy), 64'd1);
        chk("full_read_novalid", 64'(out_valid), 64'd0);
        for (int n = 0; n < 32; n++) begin
            tick();
            chk($sformatf("full_valid_%0d", n), 64'(out_valid), 64'd1);
            chk($sformatf("full_idx_%0d", n), 64'(out_idx), 64'(n));
            chk($sformatf("full_data_%0d", n), 64'(out_data), (n == 0) ? 64'd0 : 64'(32'h1000 + n));
            tick();
        end
        chk("full_done", 64'({done, err}), 64'b10);
        chk("full_cnt", 64'(beat_cnt), 64'd32);
        tick();
        chk("full_idle_busy", 64'(busy), 64'd0);
        chk("full_idle_done", 64'(done), 64'd0);
        chk("full_idle_valid", 64'(out_valid), 64'd0);

        // backpressure on beat 6 of range 5..7
        start = 1'b1; first_reg = 5'd5; last_reg = 5'd7; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("bp_idx5", 64'(out_idx), 64'd5);
        chk("bp_data5", 64'(out_data), 64'h1005);
        tick();
        out_ready = 1'b0;
        tick();
        chk("bp_valid6", 64'(out_valid), 64'd1);
        chk("bp_idx6", 64'(out_idx), 64'd6);
        chk("bp_data6", 64'(out_data), 64'h1006);
        regs[6] = 32'hBEEF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold_valid_%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold_idx_%0d", k), 64'(out_idx), 64'd6);
            chk($sformatf("bp_hold_data_%0d", k), 64'(out_data), 64'h1006);
        end
        regs[6] = 32'h1006;
        out_ready = 1'b1;
        tick();
        chk("bp_after_hs_valid", 64'(out_valid), 64'd0);
        chk("bp_after_hs_cnt", 64'(beat_cnt), 64'd2);
        tick();
        chk("bp_idx7", 64'(out_idx), 64'd7);
        chk("bp_data7", 64'(out_data), 64'h1007);
        tick();
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_cnt", 64'(beat_cnt), 64'd3);
        tick();

        // invalid range 9..3
        start = 1'b1; first_reg = 5'd9; last_reg = 5'd3;
        tick();
        start = 1'b0;
        chk("inv_done_err", 64'({done, err}), 64'b11);
        chk("inv_valid", 64'(out_valid), 64'd0);
        chk("inv_cnt", 64'(beat_cnt), 64'd0);
        tick();
        chk("inv_pulse_end", 64'({done, err}), 64'b00);
        chk("inv_idle", 64'({busy, out_valid}), 64'b00);

        // ignored start while busy, then abort on beat 2 together with ready
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd7; out_ready = 1'b1;
        tick();
        start = 1'b1; first_reg = 5'd20; last_reg = 5'd25;
        tick();
        start = 1'b0;
        chk("ab_idx0", 64'(out_idx), 64'd0);
        tick();
        tick();
        chk("ab_idx1", 64'(out_idx), 64'd1);
        tick();
        tick();
        chk("ab_idx2", 64'(out_idx), 64'd2);
        chk("ab_data2", 64'(out_data), 64'h1002);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", 64'({busy, out_valid}), 64'b00);
        chk("ab_nodone", 64'({done, err}), 64'b00);
        chk("ab_cnt", 64'(beat_cnt), 64'd2);
        tick();
        chk("ab_still_nodone", 64'({done, busy}), 64'b00);

        // live write to r4 on the negedge before beat 4's READ edge
        start = 1'b1; first_reg = 5'd3; last_reg = 5'd4; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("lw_data3", 64'(out_data), 64'h1003);
        tick();
        @(negedge clk);
        regs[4] = 32'hDEAD;
        tick();
        chk("lw_idx4", 64'(out_idx), 64'd4);
        chk("lw_data4", 64'(out_data), 64'hDEAD);
        tick();
        chk("lw_done_cnt", 64'({done, beat_cnt}), 64'({1'b1, 6'd2}));
        tick();

        // asynchronous reset in the middle of HOLD
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd7; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        chk("mr_pre_valid", 64'(out_valid), 64'd1);
        chk("mr_pre_cnt", 64'(beat_cnt), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_valid", 64'(out_valid), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_done", 64'(done), 64'd0);
        chk("mr_sel", 64'(reg_sel), 64'd0);
        chk("mr_cnt", 64'(beat_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_after_idle", 64'({busy, done, out_valid}), 64'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
